// File: rtl/keypad_if.sv
// Keypad scanner signal bundle: matrix lines on one side, key events on the other.
interface keypad_if;
    logic [3:0] key_row;   // active-low rows from the keypad
    logic [3:0] key_col;   // one-hot active-low column drive
    logic [3:0] key_code;  // last accepted key
    logic       key_valid; // one-cycle new-press strobe
    logic       key_digit; // key_code is 0-9, qualified by key_valid
    logic       key_busy;  // a key is being debounced or held

    // Scanner side
    modport master (
        input  key_row,
        output key_col,
        output key_code,
        output key_valid,
        output key_digit,
        output key_busy
    );

    // Keypad / consumer side
    modport slave (
        output key_row,
        input  key_col,
        input  key_code,
        input  key_valid,
        input  key_digit,
        input  key_busy
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 membrane keypad scanner: column rotation, 2-flop row synchroniser, press/release
// debounce, one key_valid pulse per physical press.
module keypad_scan #(
    parameter int unsigned SCAN_TICKS   = 4,
    parameter int unsigned DEBOUNCE_CNT = 20
) (
    input  logic     clk,
    input  logic     rst,
    keypad_if.master kp
);

    localparam int unsigned DW = $clog2(SCAN_TICKS + 1);
    localparam int unsigned CW = $clog2(DEBOUNCE_CNT + 1);

    typedef enum logic [1:0] {StScan, StDebPress, StHeld} state_e;

    state_e         state_q, state_d;
    logic [3:0]     rs_meta, rs;
    logic [1:0]     col_q, col_d;
    logic [DW-1:0]  dwell_q, dwell_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     lat_q, lat_d;
    logic [3:0]     code_q, code_d;
    logic           valid_q, valid_d;
    logic           digit_q, digit_d;
    logic [3:0]     press_code;
    logic           single_row;

    // Row pattern (exactly one low bit) and column to key code.
    function automatic logic [3:0] key_map(input logic [3:0] row_n, input logic [1:0] col);
        logic [1:0] r;
        logic [3:0] code;
        r = 2'd0;
        unique case (row_n)
            4'b1110: r = 2'd0;
            4'b1101: r = 2'd1;
            4'b1011: r = 2'd2;
            4'b0111: r = 2'd3;
            default: r = 2'd0;
        endcase
        case ({r, col})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'hE;
            4'd13:   code = 4'h0;
            4'd14:   code = 4'hF;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

    // Two-flop synchroniser for the asynchronous row inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rs_meta <= 4'b1111;
            rs      <= 4'b1111;
        end else begin
            rs_meta <= kp.key_row;
            rs      <= rs_meta;
        end
    end

    assign single_row = ($countones(~rs) == 1);
    // While debouncing rs equals the latched pattern, so rs decodes the key in every state.
    assign press_code = key_map(rs, col_q);

    // Next-state: scan, press debounce, release debounce.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        lat_d   = lat_q;
        code_d  = code_q;
        valid_d = 1'b0;
        digit_d = 1'b0;
        unique case (state_q)
            StScan: begin
                if (dwell_q == DW'(SCAN_TICKS - 1)) begin
                    dwell_d = '0;
                    if (single_row) begin
                        lat_d = rs;
                        if (DEBOUNCE_CNT <= 1) begin
                            valid_d = 1'b1;
                            code_d  = press_code;
                            digit_d = (press_code <= 4'd9);
                            cnt_d   = '0;
                            state_d = StHeld;
                        end else begin
                            cnt_d   = CW'(1);
                            state_d = StDebPress;
                        end
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + DW'(1);
                end
            end
            StDebPress: begin
                if (rs == lat_q) begin
                    if (cnt_q >= CW'(DEBOUNCE_CNT - 1)) begin
                        valid_d = 1'b1;
                        code_d  = press_code;
                        digit_d = (press_code <= 4'd9);
                        cnt_d   = '0;
                        state_d = StHeld;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d   = '0;
                    dwell_d = '0;
                    col_d   = col_q + 2'd1;
                    state_d = StScan;
                end
            end
            StHeld: begin
                if (rs == 4'b1111) begin
                    if (cnt_q >= CW'(DEBOUNCE_CNT - 1)) begin
                        cnt_d   = '0;
                        dwell_d = '0;
                        col_d   = col_q + 2'd1;
                        state_d = StScan;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    cnt_d = '0;
                end
            end
            default: state_d = StScan;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StScan;
            col_q   <= 2'd0;
            dwell_q <= '0;
            cnt_q   <= '0;
            lat_q   <= 4'b1111;
            code_q  <= 4'h0;
            valid_q <= 1'b0;
            digit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            lat_q   <= lat_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            digit_q <= digit_d;
        end
    end

    assign kp.key_col   = ~(4'b0001 << col_q);
    assign kp.key_code  = code_q;
    assign kp.key_valid = valid_q;
    assign kp.key_digit = digit_q;
    assign kp.key_busy  = (state_q != StScan);

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 switch matrix.
module tb_keypad_scan;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic pressed [4][4];
    logic [3:0] row_v;

    int checks   = 0;
    int failures = 0;
    int n_pulse  = 0;
    logic [3:0] last_code  = 4'h0;
    logic       last_digit = 1'b0;

    keypad_if kif ();

    keypad_scan #(
        .SCAN_TICKS   (4),
        .DEBOUNCE_CNT (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .kp  (kif)
    );

    always #5 clk = ~clk;

    // Switch matrix: a row reads low when a pressed key sits on the driven column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_v[r] = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (pressed[r][c] && !kif.key_col[c]) row_v[r] = 1'b0;
            end
        end
    end
    assign kif.key_row = row_v;

    typedef struct {
        string      name;
        int         row;
        int         col;
        int         hold;
        logic [3:0] code;
        logic       digit;
    } key_vec_t;

    key_vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One cycle: sample at the falling edge, enforce per-cycle invariants, count pulses.
    task automatic tick();
        @(negedge clk);
        check("col_onehot_low", 32'($countones(~kif.key_col)), 32'd1);
        if (kif.key_valid) begin
            n_pulse++;
            last_code  = kif.key_code;
            last_digit = kif.key_digit;
        end else begin
            check("digit_without_valid", 32'(kif.key_digit), 32'd0);
        end
    endtask

    task automatic release_all();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) pressed[r][c] = 1'b0;
    endtask

    task automatic apply_key(input key_vec_t v);
        int base;
        int first;
        int k;
        base  = n_pulse;
        first = -1;
        pressed[v.row][v.col] = 1'b1;
        for (int i = 0; i < v.hold; i++) begin
            tick();
            if (first < 0 && n_pulse != base) first = i + 1;
        end
        check({v.name, "_pulses"}, 32'(n_pulse - base), 32'd1);
        check({v.name, "_code"}, 32'(last_code), 32'(v.code));
        check({v.name, "_digit"}, 32'(last_digit), 32'(v.digit));
        check({v.name, "_latency_ok"}, 32'(first >= 1 && first <= 40), 32'd1);
        check({v.name, "_busy_held"}, 32'(kif.key_busy), 32'd1);
        pressed[v.row][v.col] = 1'b0;
        k = 0;
        do begin
            tick();
            k++;
        end while (kif.key_busy && k < 60);
        // 2 synchroniser cycles + 20 stable release cycles
        check({v.name, "_release_cycles"}, 32'(k), 32'd22);
        check({v.name, "_no_repeat"}, 32'(n_pulse - base), 32'd1);
        repeat (5) tick();
    endtask

    initial begin
        int base;
        int k;
        logic [3:0] seen;
        logic busy_seen;

        release_all();
        vecs[0] = '{"key5", 1, 1, 60,  4'h5, 1'b1};
        vecs[1] = '{"keyA", 0, 3, 60,  4'hA, 1'b0};
        vecs[2] = '{"keyStar", 3, 0, 60, 4'hE, 1'b0};
        vecs[3] = '{"key0", 3, 1, 60,  4'h0, 1'b1};
        vecs[4] = '{"keyD", 3, 3, 60,  4'hD, 1'b0};
        vecs[5] = '{"key1", 0, 0, 60,  4'h1, 1'b1};
        vecs[6] = '{"keyHashLong", 3, 2, 500, 4'hF, 1'b0};
        vecs[7] = '{"key8", 2, 1, 60,  4'h8, 1'b1};

        // Reset state
        repeat (3) tick();
        check("rst_col", 32'(kif.key_col), 32'hE);
        check("rst_valid", 32'(kif.key_valid), 32'd0);
        check("rst_code", 32'(kif.key_code), 32'd0);
        check("rst_digit", 32'(kif.key_digit), 32'd0);
        check("rst_busy", 32'(kif.key_busy), 32'd0);
        rst = 1'b1;
        repeat (4) tick();

        for (int i = 0; i < 8; i++) apply_key(vecs[i]);

        // Bounce: row0 low for 6 cycles while col2 is driven
        k = 0;
        while (kif.key_col != 4'b1011 && k < 40) begin
            tick();
            k++;
        end
        check("bounce_col2_reached", 32'(kif.key_col), 32'hB);
        base = n_pulse;
        pressed[0][2] = 1'b1;
        repeat (6) tick();
        pressed[0][2] = 1'b0;
        seen = 4'h0;
        for (int i = 0; i < 40; i++) begin
            tick();
            seen |= ~kif.key_col;
        end
        check("bounce_no_pulse", 32'(n_pulse - base), 32'd0);
        check("bounce_busy", 32'(kif.key_busy), 32'd0);
        check("bounce_scanning", 32'(seen), 32'hF);

        // Two rows low on col0: ambiguous, ignored
        base = n_pulse;
        busy_seen = 1'b0;
        pressed[0][0] = 1'b1;
        pressed[2][0] = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            busy_seen |= kif.key_busy;
        end
        check("multi_no_pulse", 32'(n_pulse - base), 32'd0);
        check("multi_never_busy", 32'(busy_seen), 32'd0);
        release_all();
        repeat (10) tick();
        apply_key('{"key7_after_multi", 2, 0, 60, 4'h7, 1'b1});

        // Reset while a key is held, key still held afterwards
        base = n_pulse;
        pressed[2][2] = 1'b1;
        k = 0;
        while (n_pulse == base && k < 60) begin
            tick();
            k++;
        end
        check("key9_first_pulse", 32'(n_pulse - base), 32'd1);
        check("key9_first_code", 32'(last_code), 32'h9);
        repeat (10) tick();
        check("key9_held_busy", 32'(kif.key_busy), 32'd1);
        rst = 1'b0;
        repeat (3) tick();
        check("midrst_col", 32'(kif.key_col), 32'hE);
        check("midrst_code", 32'(kif.key_code), 32'd0);
        check("midrst_valid", 32'(kif.key_valid), 32'd0);
        check("midrst_busy", 32'(kif.key_busy), 32'd0);
        rst = 1'b1;
        base = n_pulse;
        for (int i = 0; i < 60; i++) tick();
        check("key9_after_rst_pulses", 32'(n_pulse - base), 32'd1);
        check("key9_after_rst_code", 32'(last_code), 32'h9);
        check("key9_after_rst_digit", 32'(last_digit), 32'd1);
        check("key9_code_held", 32'(kif.key_code), 32'h9);
        release_all();
        k = 0;
        do begin
            tick();
            k++;
        end while (kif.key_busy && k < 60);
        check("key9_release_cycles", 32'(k), 32'd22);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
